serial_adder: RTL

Bit-serial ripple adder that sums two WIDTH-bit operands plus carry-in, LSB first, one bit per clock, through a single one-bit full-adder cell and a carry flip-flop. It performs the additive counterpart of the team's full-subtractor datapath. It sits next to the arithmetic cells as the area-minimal adder for multi-bit operands, and exchanges operands and results with its requester through a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder_fa.sv | 15 +
 rtl/serial_adder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the controller state
//   encoding and a helper sizing the bit counter for a given operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Start/done request bundle between a requester and the serial adder.
//   Signals: start, a, b, cin (requester -> adder);
//            busy, done, sum, cout (adder -> requester).
//   Modports: master = requester side, slave = adder side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_fa.sv
// fa
//   One-bit full-adder cell used as the datapath slice of the serial adder.
//   Ports: a, b, c (operand bits and carry in); sum, carry (results).
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Adds two WIDTH-bit unsigned operands plus carry-in, LSB first, one bit
//   per clock through a single full-adder cell and a carry flop.
//   Ports: clk, rst_n (async active-low reset);
//          bus (slave side of serial_adder_if: start/a/b/cin in,
//               busy/done/sum/cout out, all outputs registered).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_if.slave      bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_shift_s;

  fa u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // Next-state and datapath update for the controller and shift registers.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
    acc_shift_s            = acc_q >> 1'b1;
    acc_shift_s[WIDTH-1]   = fa_s;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1'b1;
        b_sr_d  = b_sr_q >> 1'b1;
        acc_d   = acc_shift_s;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the result together with the done pulse.
          sum_d   = acc_shift_s;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
